pwm_fade_ctrl: RTL

Duty-cycle sequencer for the basic PWM generator: ramps duty from 0 up to a programmed target, holds it, then ramps back to 0. All duty updates are aligned to PWM period boundaries. Sits between the control logic and the PWM datapath, and drives its `duty` and `enable` inputs.

---
 rtl/pwm_fade_pkg.sv | 7 +
 rtl/pwm_fade_ctrl_if.sv | 7 +
 rtl/pwm_period_timer.sv | 30 +++
 rtl/pwm_fade_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: state encoding and default parameters shared by the PWM fade sequencer.
package pwm_fade_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, HOLD = 2'd2, DOWN = 2'd3} state_e;
  localparam int R_DEF = 8;
  localparam int STEP_PERIODS_DEF = 4;
  localparam int HOLD_PERIODS_DEF = 16;
endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// pwm_fade_ctrl_if: control requests in, duty/enable/status out of the fade sequencer.
interface pwm_fade_ctrl_if #(parameter int R = pwm_fade_pkg::R_DEF);
  logic start, stop, pwm_en, period_end, busy, done;
  logic [R-1:0] target, step, duty;
  modport master (output start, stop, target, step, input duty, pwm_en, period_end, busy, done);
  modport slave (input start, stop, target, step, output duty, pwm_en, period_end, busy, done);
endinterface

// File: rtl/pwm_period_timer.sv
// pwm_period_timer: PWM period counter, end-of-period strobe and a clearable period divider.
module pwm_period_timer #(
  parameter int R = 8,
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          clr,
  input  logic [DW-1:0] limit,
  output logic          period_end,
  output logic          tick
);
  logic [R-1:0] pcnt_q, pcnt_d;
  logic [DW-1:0] div_q, div_d;
  always_comb begin
    period_end = run && (&pcnt_q);
    tick = period_end && (div_q == limit - 1'b1);
    pcnt_d = run ? pcnt_q + 1'b1 : '0;
    div_d = (clr || tick) ? '0 : period_end ? div_q + 1'b1 : div_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pcnt_q <= '0;
      div_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      div_q <= div_d;
    end
endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: period-aligned duty ramp up / hold / ramp down sequencer.
// Define PWM_FADE_LOOP_EN for breathing mode (repeat until stop is requested).
module pwm_fade_ctrl import pwm_fade_pkg::*; #(
  parameter int R = R_DEF,
  parameter int STEP_PERIODS = STEP_PERIODS_DEF,
  parameter int HOLD_PERIODS = HOLD_PERIODS_DEF
) (
  input logic clk,
  input logic reset,
  pwm_fade_ctrl_if.slave bus
);
  localparam int MAXP = STEP_PERIODS > HOLD_PERIODS ? STEP_PERIODS : HOLD_PERIODS;
  localparam int DW = $clog2(MAXP + 1);
  localparam logic [DW-1:0] STEP_L = DW'(STEP_PERIODS);
  localparam logic [DW-1:0] HOLD_L = DW'(HOLD_PERIODS);
  state_e state_q, state_d;
  logic [R-1:0] duty_q, duty_d, tgt_q, tgt_d, stp_q, stp_d, up_duty, dn_duty;
  logic [R:0] up_sum;
  logic [DW-1:0] limit;
  logic done_q, done_d, busy, period_end, tick, clr, fin;
`ifdef PWM_FADE_LOOP_EN
  logic stop_req_q, stop_req_d;
`endif
  pwm_period_timer #(.R(R), .DW(DW)) u_tmr (
    .clk(clk), .reset(reset), .run(busy), .clr(clr), .limit(limit),
    .period_end(period_end), .tick(tick)
  );
  // Sums use an extra bit so saturation at target cannot wrap.
  always_comb begin
    busy = state_q != IDLE;
    limit = state_q == HOLD ? HOLD_L : STEP_L;
    up_sum = {1'b0, duty_q} + {1'b0, stp_q};
    up_duty = up_sum >= {1'b0, tgt_q} ? tgt_q : up_sum[R-1:0];
    dn_duty = duty_q > stp_q ? duty_q - stp_q : '0;
`ifdef PWM_FADE_LOOP_EN
    fin = stop_req_q || bus.stop;
    stop_req_d = busy && (stop_req_q || bus.stop);
`else
    fin = 1'b1;
`endif
    state_d = state_q;
    duty_d = duty_q;
    tgt_d = tgt_q;
    stp_d = stp_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        tgt_d = bus.target;
        stp_d = bus.step == '0 ? R'(1) : bus.step;
        duty_d = '0;
        state_d = bus.target == '0 ? IDLE : UP;
        done_d = bus.target == '0;
      end
    end else if (bus.stop && state_q != DOWN) begin
      state_d = DOWN;
    end else if (tick) begin
      if (state_q == UP) begin
        duty_d = up_duty;
        state_d = up_duty == tgt_q ? HOLD : UP;
      end else if (state_q == HOLD) begin
        state_d = DOWN;
      end else begin
        duty_d = dn_duty;
        if (dn_duty == '0) begin
          state_d = fin ? IDLE : UP;
          done_d = fin;
        end
      end
    end
    clr = state_d != state_q || !busy;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      duty_q <= '0;
      tgt_q <= '0;
      stp_q <= '0;
      done_q <= 1'b0;
`ifdef PWM_FADE_LOOP_EN
      stop_req_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      duty_q <= duty_d;
      tgt_q <= tgt_d;
      stp_q <= stp_d;
      done_q <= done_d;
`ifdef PWM_FADE_LOOP_EN
      stop_req_q <= stop_req_d;
`endif
    end
  assign bus.duty = duty_q;
  assign bus.pwm_en = busy;
  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.period_end = period_end;
endmodule
